uart_frame_rx: RTL
==================

// Module: uart_frame_rx
// PURPOSE
//  Packet deframer on the receive side of the uart_core byte interface.
//  - Consumes raw bytes and finds frames: [SOF][LEN][LEN payload bytes][CHK].
//  - Holds each payload until its checksum has been verified.
//  - Streams a verified payload out with valid/ready/last. Bad frames are dropped and reported on error pulses.
// PARAMETERS
//  MAX_LEN        32       max payload bytes per frame (1..255); sets buffer depth
//  SOF            8'hA5    start-of-frame marker byte
//  TIMEOUT_CYCLES 50000    max idle clocks between bytes inside a frame; 0 disables timeout
// PORTS
//  clk          in   1  system clock
//  rst          in   1  reset: synchronous, active-high
//  in_data      in   8  received byte (from uart_core rx_data)
//  in_valid     in   1  in_data valid; uart_core drives this as a 1-cycle pulse
//  in_ready     out  1  byte accepted when in_valid&&in_ready
//  out_data     out  8  payload byte
//  out_valid    out  1  out_data valid
//  out_last     out  1  marks final payload byte of the frame
//  out_ready    in   1  downstream accepts a beat when out_valid&&out_ready
//  frame_ok     out  1  1-cycle pulse: good frame committed (on CHK accept)
//  err_chk      out  1  1-cycle pulse: checksum mismatch; frame dropped
//  err_len      out  1  1-cycle pulse: LEN==0 or LEN>MAX_LEN; frame dropped
//  err_timeout  out  1  1-cycle pulse: inter-byte timeout; frame dropped
//  err_overrun  out  1  1-cycle pulse: in_valid seen while in_ready=0; byte lost
// BEHAVIOUR
//  - Reset values: state=IDLE; all outputs 0 except in_ready=1; buffer content undefined.
//  - Reset mid-operation discards any partial or buffered frame. out_valid is 0 after the reset edge.
//  - States:
//    - IDLE: bytes != SOF are discarded silently; SOF -> LEN.
//    - LEN: store len, seed sum=LEN.
//      - 1<=LEN<=MAX_LEN -> PAYLOAD.
//      - Otherwise pulse err_len -> IDLE. No rescan inside the rejected frame.
//    - PAYLOAD: write byte to buf[wr_idx]; sum += byte; after the len-th byte -> CHK.
//    - CHK: if (sum+CHK)[7:0]==0, pulse frame_ok -> DRAIN; else pulse err_chk -> IDLE.
//    - DRAIN:
//      - out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==len-1).
//      - rd_idx advances on each handshake.
//      - The last handshake -> IDLE, with out_valid=0 on the next cycle.
//  - Flow control:
//    - in_ready=1 in IDLE/LEN/PAYLOAD/CHK and 0 in DRAIN.
//    - in_valid in DRAIN pulses err_overrun; the byte is dropped and the state is unchanged.
//  - Latency: out_valid rises on the cycle after the CHK byte is accepted; 1 beat/cycle thereafter with out_ready=1.
//  - Outputs hold stable while out_valid&&!out_ready.
//  - Arithmetic: sum is 8-bit modulo 256. wr_idx and rd_idx are $clog2(MAX_LEN) bits and never wrap past len-1.
//  - Timeout:
//    - Counter clears on every accepted byte and counts in LEN/PAYLOAD/CHK.
//    - At TIMEOUT_CYCLES-1 with no byte: pulse err_timeout -> IDLE.
//    - Byte arriving on the timeout cycle wins (accepted, no error).
//    - Not active in IDLE or DRAIN.
//  - Error pulses are registered, mutually exclusive per cycle, and never coincide with out_valid rising.
// STRUCTURE
//  - uart_pkg holds: the frame state enum (IDLE,LEN,PAYLOAD,CHK,DRAIN), the default SOF constant, and the function chk8(sum,byte).
//  - One sub-module: uart_frame_buf, a MAX_LEN x 8 register array with 1 sync write port and 1 async read port.
//  - FSM, counters and timeout live in uart_frame_rx.
// TESTING
//  1 A5 03 11 22 33 97 -> frame_ok pulse; out beats 11,22,33; out_last only on 33.
//  2 A5 03 11 22 33 98 -> err_chk pulse; out_valid never asserts.
//  3 A5 00, then A5 21 (MAX_LEN=32) -> two err_len pulses, no output.
//  4 00 FF A5 01 7E 81 -> garbage ignored; single beat 7E with out_last=1.
//  5 Case 1 with out_ready low 5 cycles after first beat, plus byte 55 during DRAIN:
//    - out_data holds 22 and out_valid stays high while out_ready is low.
//    - err_overrun pulses once; remaining beats are intact.
//  6 Timeout and reset recovery:
//    - A5 02 11 then TIMEOUT_CYCLES idle -> err_timeout; next A5 01 7E 81 is accepted.
//    - rst mid-PAYLOAD -> IDLE, no output.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart frame receive path.
//   frame_state_e : deframer state encoding
//   SOF_DEFAULT   : default start-of-frame marker
//   chk8()        : running 8-bit modulo-256 checksum step
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHK,
        DRAIN
    } frame_state_e;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Add one byte into the running modulo-256 sum.
    function automatic logic [7:0] chk8(input logic [7:0] sum, input logic [7:0] data);
        return 8'(sum + data);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: DEPTH x 8 register array, one synchronous write
// port and one asynchronous read port. Contents are not reset.
//   clk   in   clock
//   we    in   write enable
//   waddr in   write address
//   wdata in   write data
//   raddr in   read address
//   rdata out  read data (combinational from raddr)
module uart_frame_buf #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port.
    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Packet deframer on the receive side of the uart_core byte interface.
// Finds [SOF][LEN][payload][CHK] frames, buffers the payload until the
// checksum verifies, then streams it out with valid/ready/last.
//   clk, rst                 clock, synchronous active-high reset
//   in_data/in_valid/in_ready byte input (in_ready low only while draining)
//   out_data/out_valid/out_last/out_ready  payload stream
//   frame_ok                 pulse: good frame committed
//   err_chk/err_len/err_timeout/err_overrun  pulses: frame or byte dropped
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 32,
    parameter logic [7:0]  SOF            = SOF_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_overrun
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]  MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    frame_state_e     state, state_nxt;
    logic [7:0]       len, len_nxt;
    logic [7:0]       sum, sum_nxt;
    logic [IDX_W-1:0] wr_idx, wr_idx_nxt;
    logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;

    logic             in_ready_nxt;
    logic [7:0]       out_data_nxt;
    logic             out_valid_nxt, out_last_nxt;
    logic             frame_ok_nxt, err_chk_nxt, err_len_nxt, err_timeout_nxt, err_overrun_nxt;

    logic             buf_we;
    logic [IDX_W-1:0] rd_addr;
    logic [7:0]       rd_data;

    logic             accept;
    logic             tmo_hit;
    logic [IDX_W-1:0] rd_idx_inc;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (IDX_W)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_idx),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign accept     = in_valid && in_ready;
    assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
    assign rd_idx_inc = rd_idx + IDX_W'(1);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len         <= '0;
            sum         <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            tmo_cnt     <= '0;
            in_ready    <= 1'b1;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            frame_ok    <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            len         <= len_nxt;
            sum         <= sum_nxt;
            wr_idx      <= wr_idx_nxt;
            rd_idx      <= rd_idx_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            in_ready    <= in_ready_nxt;
            out_data    <= out_data_nxt;
            out_valid   <= out_valid_nxt;
            out_last    <= out_last_nxt;
            frame_ok    <= frame_ok_nxt;
            err_chk     <= err_chk_nxt;
            err_len     <= err_len_nxt;
            err_timeout <= err_timeout_nxt;
            err_overrun <= err_overrun_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        len_nxt         = len;
        sum_nxt         = sum;
        wr_idx_nxt      = wr_idx;
        rd_idx_nxt      = rd_idx;
        tmo_cnt_nxt     = '0;
        out_data_nxt    = out_data;
        out_valid_nxt   = out_valid;
        out_last_nxt    = out_last;
        frame_ok_nxt    = 1'b0;
        err_chk_nxt     = 1'b0;
        err_len_nxt     = 1'b0;
        err_timeout_nxt = 1'b0;
        err_overrun_nxt = 1'b0;
        buf_we          = 1'b0;
        rd_addr         = rd_idx;

        // Inter-byte timeout inside a frame; an arriving byte always wins.
        if (state == LEN || state == PAYLOAD || state == CHK) begin
            if (!accept) begin
                if (tmo_hit) begin
                    err_timeout_nxt = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
        end

        case (state)
            IDLE: begin
                if (accept && in_data == SOF) begin
                    state_nxt = LEN;
                end
            end

            LEN: begin
                if (accept) begin
                    len_nxt    = in_data;
                    sum_nxt    = in_data;
                    wr_idx_nxt = '0;
                    if (in_data != 8'd0 && in_data <= MAX_LEN_B) begin
                        state_nxt = PAYLOAD;
                    end else begin
                        err_len_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end

            PAYLOAD: begin
                if (accept) begin
                    buf_we  = 1'b1;
                    sum_nxt = chk8(sum, in_data);
                    if (8'(wr_idx) == len - 8'd1) begin
                        state_nxt = CHK;
                    end else begin
                        wr_idx_nxt = wr_idx + IDX_W'(1);
                    end
                end
            end

            CHK: begin
                if (accept) begin
                    if (chk8(sum, in_data) == 8'd0) begin
                        // Preload the first beat so out_valid rises next cycle.
                        frame_ok_nxt  = 1'b1;
                        state_nxt     = DRAIN;
                        rd_idx_nxt    = '0;
                        rd_addr       = '0;
                        out_data_nxt  = rd_data;
                        out_valid_nxt = 1'b1;
                        out_last_nxt  = (len == 8'd1);
                    end else begin
                        err_chk_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end

            DRAIN: begin
                if (in_valid) begin
                    err_overrun_nxt = 1'b1;
                end
                if (out_ready) begin
                    if (out_last) begin
                        state_nxt     = IDLE;
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                    end else begin
                        rd_idx_nxt    = rd_idx_inc;
                        rd_addr       = rd_idx_inc;
                        out_data_nxt  = rd_data;
                        out_last_nxt  = (8'(rd_idx_inc) == len - 8'd1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        in_ready_nxt = (state_nxt != DRAIN);
    end

endmodule
